// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecc_pkg
// Brief    : Shared field constants and state type for the GF(2^255-19) stages.
// Revision : 1.0 - initial release
// ============================================================================
package ecc_pkg;

    localparam int W = 255;

    localparam logic [W-1:0] P25519 =
        255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ffm_step.sv
`default_nettype none
// ============================================================================
// Module   : ffm_step
// Brief    : One double-and-add step of the interleaved modular multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module ffm_step
    import ecc_pkg::*;
(
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a,
    input  logic         mbit,
    output logic [W-1:0] next
);

    localparam logic [W+1:0] c_p_wide = {2'b00, P25519};

    logic [W+1:0] w_t;
    logic [W+1:0] w_u;
    logic [W+1:0] w_v;

    // Canonical acc and a keep t below 3p, so two conditional subtracts suffice.
    always_comb begin
        w_t  = {1'b0, acc, 1'b0} + (mbit ? {2'b00, a} : {(W+2){1'b0}});
        w_u  = (w_t >= c_p_wide) ? (w_t - c_p_wide) : w_t;
        w_v  = (w_u >= c_p_wide) ? (w_u - c_p_wide) : w_u;
        next = w_v[W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/ffm.sv
`default_nettype none
// ============================================================================
// Module   : ffm
// Brief    : Sequential MSB-first modular multiplier over GF(2^255-19).
// Revision : 1.0 - initial release
// ============================================================================
module ffm
    import ecc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         valid,
    output logic         busy
);

    localparam logic [7:0] c_cnt_init = 8'(W - 1);

    state_e       r_state;
    state_e       w_state_nxt;
    logic [7:0]   r_cnt;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_result;
    logic         r_valid;
    logic [W-1:0] w_step;
    logic         w_accept;
    logic         w_done;

    ffm_step u_step (
        .acc  (r_acc),
        .a    (r_a),
        .mbit (r_b[r_cnt]),
        .next (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == 8'd0) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_done;
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_acc <= '0;
                r_cnt <= c_cnt_init;
            end else if (r_state == RUN) begin
                r_acc <= w_step;
                if (r_cnt != 8'd0) begin
                    r_cnt <= r_cnt - 8'd1;
                end
            end
            if (w_done) begin
                r_result <= w_step;
            end
        end
    end

    assign result = r_result;
    assign valid  = r_valid;
    assign busy   = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_ffm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ffm
// Brief    : Self-checking bench for ffm against an a*b mod p reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ffm;

    localparam logic [254:0] TB_P =
        255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
    localparam int N_RANDOM = 200;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [254:0] a;
    logic [254:0] b;
    logic [254:0] result;
    logic         valid;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    ffm dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [254:0] ref_mul(input logic [254:0] x, input logic [254:0] y);
        logic [511:0] prod;
        prod = 512'(x) * 512'(y);
        prod = prod % 512'(TB_P);
        return prod[254:0];
    endfunction

    function automatic logic [254:0] rnd_fe();
        logic [255:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            t = {t[223:0], 32'($urandom)};
        end
        case ($urandom_range(0, 7))
            0:       return TB_P - 255'($urandom_range(1, 40));
            1:       return 255'($urandom_range(0, 40));
            default: return (t[254:0] >= TB_P) ? (t[254:0] - TB_P) : t[254:0];
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && valid && busy) begin
            check("valid_busy_overlap", 256'(1), 256'(0));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic start_op(input logic [254:0] x, input logic [254:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 256'(busy), 256'(1));
    endtask

    // Returns at #1 after the edge that raised valid; poke_at injects a stray start.
    task automatic wait_done(input string tag, input int poke_at, input bit scramble,
                             output logic [254:0] res);
        int lat;
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (valid || lat >= 300) break;
            if (lat == poke_at) begin
                start = 1'b1;
                a     = 255'd9;
                b     = 255'd9;
            end else begin
                start = 1'b0;
                if (scramble) begin
                    a = rnd_fe();
                    b = rnd_fe();
                end
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 256'(lat), 256'(255));
        check({tag, "_canonical"}, 256'(result < TB_P), 256'(1));
        res = result;
    endtask

    task automatic run_op(input string tag, input logic [254:0] x, input logic [254:0] y,
                          input bit scramble, input logic [254:0] exp);
        logic [254:0] r;
        start_op(x, y);
        wait_done(tag, -1, scramble, r);
        check(tag, 256'(r), 256'(exp));
        @(posedge clk);
        #1;
        check({tag, "_vpulse"}, 256'(valid), 256'(0));
    endtask

    task automatic count_valids(input string tag, input int cycles);
        int nv;
        nv = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        check(tag, 256'(nv), 256'(0));
    endtask

    initial begin
        logic [254:0] r;
        logic [254:0] x;
        logic [254:0] y;
        logic [254:0] p2_254;
        logic [254:0] exp_sq;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", 256'(result), 256'(0));
        check("reset_valid", 256'(valid), 256'(0));
        check("reset_busy", 256'(busy), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        p2_254      = '0;
        p2_254[254] = 1'b1;
        // 2^508 = 19*2^253 = 2^257 + 3*2^253, and 2^257 folds to 76.
        exp_sq          = 255'd76;
        exp_sq[254:253] = 2'b11;

        run_op("zero", 255'd0, 255'd12345, 1'b0, 255'd0);
        run_op("identity", 255'd1, TB_P - 255'd1, 1'b0, TB_P - 255'd1);
        run_op("pm1_sq", TB_P - 255'd1, TB_P - 255'd1, 1'b0, 255'd1);
        run_op("two_x_2e254", 255'd2, p2_254, 1'b0, 255'd19);
        run_op("2e254_sq", p2_254, p2_254, 1'b0, exp_sq);

        // Back-to-back with a stray start during the second run.
        start_op(255'd3, 255'd5);
        wait_done("b2b1", -1, 1'b0, r);
        check("b2b1_result", 256'(r), 256'(15));
        a     = 255'd7;
        b     = 255'd11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b2_busy", 256'(busy), 256'(1));
        check("b2b2_valid_low", 256'(valid), 256'(0));
        wait_done("b2b2", 100, 1'b0, r);
        check("b2b2_result", 256'(r), 256'(77));
        count_valids("no_third_valid", 300);

        // Reset in the middle of a run.
        start_op(TB_P - 255'd1, TB_P - 255'd1);
        repeat (99) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_result", 256'(result), 256'(0));
        check("midrst_valid", 256'(valid), 256'(0));
        check("midrst_busy", 256'(busy), 256'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_valids("no_valid_after_reset", 300);
        run_op("after_reset", 255'd4, 255'd4, 1'b0, 255'd16);

        run_op("latching", 255'd123456789, 255'd987654321, 1'b1,
               255'd121932631112635269);

        for (int i = 0; i < N_RANDOM; i++) begin
            x = rnd_fe();
            y = rnd_fe();
            run_op("random", x, y, 1'b1, ref_mul(x, y));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
